// File: rtl/pc_high_if.sv
// Bundle between the PCL stage / control unit and the PCH stage.
// Carries the carry handshake, fix-up strobes, data bus and PCH outputs.
interface pc_high_if;
  logic       load_pch;
  logic [7:0] db_in;
  logic       carry_to_pch;
  logic       carry_done;
  logic       fix_inc;
  logic       fix_dec;
  logic [7:0] address_high_out;
  logic [7:0] db_out;
  logic       busy;
  logic       wrap;
  logic       fix_err;

  modport master (
    output load_pch, db_in, carry_to_pch,
    output fix_inc, fix_dec,
    input  carry_done, address_high_out, db_out,
    input  busy, wrap, fix_err
  );

  modport slave (
    input  load_pch, db_in, carry_to_pch,
    input  fix_inc, fix_dec,
    output carry_done, address_high_out, db_out,
    output busy, wrap, fix_err
  );
endinterface

// File: rtl/pc_high.sv
// 65C02 program counter high byte: carry absorb, branch page
// fix-up, direct load, and PCH drive onto address/data buses.
module pc_high #(
  parameter logic [7:0] RESET_VALUE  = 8'hFF,
  parameter bit         ENABLE_FIXUP = 1'b1
) (
  input logic  fclk,
  input logic  reset,
  pc_high_if.slave bus
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t     state, state_n;
  logic [7:0] pch, pch_n;
  logic       wrap_q, wrap_n;
  logic       err_q, err_n;

  logic       accept;
  logic       inc_eff, dec_eff, both;
  logic [7:0] p1;

  // Next-state: load wins, otherwise carry then fix-up chained
  always_comb begin
    state_n = state;
    pch_n   = pch;
    wrap_n  = 1'b0;
    err_n   = err_q;
    p1      = pch;
    accept  = (state == IDLE) && bus.carry_to_pch;
    both    = ENABLE_FIXUP && bus.fix_inc && bus.fix_dec;
    inc_eff = ENABLE_FIXUP && bus.fix_inc && !bus.fix_dec;
    dec_eff = ENABLE_FIXUP && bus.fix_dec && !bus.fix_inc;

    if (both)
      err_n = 1'b1;

    unique case (state)
      IDLE: if (bus.carry_to_pch) state_n = ACK;
      ACK:  if (!bus.carry_to_pch) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (bus.load_pch) begin
      pch_n = bus.db_in;
    end else begin
      if (accept) begin
        p1 = pch + 8'd1;
        if (pch == 8'hFF) wrap_n = 1'b1;
      end
      pch_n = p1;
      if (inc_eff) begin
        pch_n = p1 + 8'd1;
        if (p1 == 8'hFF) wrap_n = 1'b1;
      end else if (dec_eff) begin
        pch_n = p1 - 8'd1;
        if (p1 == 8'h00) wrap_n = 1'b1;
      end
    end
  end

  // State and PCH registers; reset aborts any handshake
  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pch    <= RESET_VALUE;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      pch    <= pch_n;
      wrap_q <= wrap_n;
      err_q  <= err_n;
    end
  end

  assign bus.address_high_out = pch;
  assign bus.db_out           = pch;
  assign bus.carry_done       = (state == ACK);
  assign bus.busy             = (state == ACK);
  assign bus.wrap             = wrap_q;
  assign bus.fix_err          = err_q;

endmodule

// File: tb/tb_pc_high.sv
// Directed bench for pc_high: carry handshake, wrap, load
// priority, combined carry+fix-up, fix error and async reset.
module tb_pc_high;
  logic fclk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  pc_high_if ifc();

  pc_high dut (
    .fclk  (fclk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 fclk = ~fclk;

  task automatic idle_in();
    ifc.load_pch     = 1'b0;
    ifc.db_in        = 8'h00;
    ifc.carry_to_pch = 1'b0;
    ifc.fix_inc      = 1'b0;
    ifc.fix_dec      = 1'b0;
  endtask

  task automatic step();
    @(posedge fclk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    ifc.load_pch = 1'b1;
    ifc.db_in    = v;
    step();
    ifc.load_pch = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if (ifc.address_high_out !== 8'hFF || ifc.db_out !== 8'hFF) begin
      fails++;
      $display("FAIL reset_pch got=%h/%h exp=ff",
               ifc.address_high_out, ifc.db_out);
    end
    tests++;
    if ({ifc.carry_done, ifc.busy, ifc.wrap, ifc.fix_err} !== 4'b0) begin
      fails++;
      $display("FAIL reset_flags got=%b exp=0000",
               {ifc.carry_done, ifc.busy, ifc.wrap, ifc.fix_err});
    end
  endtask

  task automatic test_carry();
    load(8'h12);
    tests++;
    if (ifc.address_high_out !== 8'h12) begin
      fails++;
      $display("FAIL t1_load got=%h exp=12", ifc.address_high_out);
    end
    ifc.carry_to_pch = 1'b1;
    step();
    tests++;
    if (ifc.address_high_out !== 8'h13 || ifc.carry_done !== 1'b1 ||
        ifc.busy !== 1'b1) begin
      fails++;
      $display("FAIL t1_inc pch=%h done=%b busy=%b exp=13/1/1",
               ifc.address_high_out, ifc.carry_done, ifc.busy);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (ifc.address_high_out !== 8'h13 || ifc.carry_done !== 1'b1) begin
        fails++;
        $display("FAIL t1_hold%0d pch=%h done=%b exp=13/1",
                 i, ifc.address_high_out, ifc.carry_done);
      end
    end
    ifc.carry_to_pch = 1'b0;
    step();
    tests++;
    if (ifc.address_high_out !== 8'h13 || ifc.carry_done !== 1'b0 ||
        ifc.busy !== 1'b0) begin
      fails++;
      $display("FAIL t1_drop pch=%h done=%b busy=%b exp=13/0/0",
               ifc.address_high_out, ifc.carry_done, ifc.busy);
    end
  endtask

  task automatic test_wrap();
    load(8'hFF);
    ifc.carry_to_pch = 1'b1;
    step();
    tests++;
    if (ifc.address_high_out !== 8'h00 || ifc.wrap !== 1'b1) begin
      fails++;
      $display("FAIL t2_inc_wrap pch=%h wrap=%b exp=00/1",
               ifc.address_high_out, ifc.wrap);
    end
    ifc.carry_to_pch = 1'b0;
    step();
    tests++;
    if (ifc.wrap !== 1'b0 || ifc.carry_done !== 1'b0) begin
      fails++;
      $display("FAIL t2_wrap_pulse wrap=%b done=%b exp=0/0",
               ifc.wrap, ifc.carry_done);
    end
    ifc.fix_dec = 1'b1;
    step();
    ifc.fix_dec = 1'b0;
    tests++;
    if (ifc.address_high_out !== 8'hFF || ifc.wrap !== 1'b1) begin
      fails++;
      $display("FAIL t2_dec_wrap pch=%h wrap=%b exp=ff/1",
               ifc.address_high_out, ifc.wrap);
    end
    step();
    tests++;
    if (ifc.wrap !== 1'b0 || ifc.address_high_out !== 8'hFF) begin
      fails++;
      $display("FAIL t2_dec_pulse wrap=%b pch=%h exp=0/ff",
               ifc.wrap, ifc.address_high_out);
    end
  endtask

  task automatic test_load_priority();
    ifc.load_pch     = 1'b1;
    ifc.db_in        = 8'hA5;
    ifc.carry_to_pch = 1'b1;
    step();
    ifc.load_pch = 1'b0;
    tests++;
    if (ifc.address_high_out !== 8'hA5 || ifc.carry_done !== 1'b1 ||
        ifc.wrap !== 1'b0) begin
      fails++;
      $display("FAIL t3_load pch=%h done=%b wrap=%b exp=a5/1/0",
               ifc.address_high_out, ifc.carry_done, ifc.wrap);
    end
    ifc.carry_to_pch = 1'b0;
    step();
    tests++;
    if (ifc.address_high_out !== 8'hA5 || ifc.carry_done !== 1'b0) begin
      fails++;
      $display("FAIL t3_release pch=%h done=%b exp=a5/0",
               ifc.address_high_out, ifc.carry_done);
    end
  endtask

  task automatic test_carry_fix();
    load(8'h30);
    ifc.carry_to_pch = 1'b1;
    ifc.fix_inc      = 1'b1;
    step();
    ifc.fix_inc = 1'b0;
    tests++;
    if (ifc.address_high_out !== 8'h32 || ifc.busy !== 1'b1) begin
      fails++;
      $display("FAIL t4_inc pch=%h busy=%b exp=32/1",
               ifc.address_high_out, ifc.busy);
    end
    ifc.carry_to_pch = 1'b0;
    step();
    load(8'h30);
    ifc.carry_to_pch = 1'b1;
    ifc.fix_dec      = 1'b1;
    step();
    ifc.fix_dec = 1'b0;
    tests++;
    if (ifc.address_high_out !== 8'h30 || ifc.busy !== 1'b1 ||
        ifc.carry_done !== 1'b1) begin
      fails++;
      $display("FAIL t4_dec pch=%h busy=%b done=%b exp=30/1/1",
               ifc.address_high_out, ifc.busy, ifc.carry_done);
    end
    ifc.carry_to_pch = 1'b0;
    step();
  endtask

  task automatic test_fix_in_ack();
    load(8'h10);
    ifc.carry_to_pch = 1'b1;
    step();
    ifc.fix_inc = 1'b1;
    step();
    ifc.fix_inc = 1'b0;
    tests++;
    if (ifc.address_high_out !== 8'h12 || ifc.busy !== 1'b1) begin
      fails++;
      $display("FAIL ack_fix pch=%h busy=%b exp=12/1",
               ifc.address_high_out, ifc.busy);
    end
    ifc.carry_to_pch = 1'b0;
    step();
    tests++;
    if (ifc.address_high_out !== 8'h12 || ifc.busy !== 1'b0) begin
      fails++;
      $display("FAIL ack_fix_exit pch=%h busy=%b exp=12/0",
               ifc.address_high_out, ifc.busy);
    end
  endtask

  task automatic test_fix_err();
    load(8'h40);
    ifc.fix_inc = 1'b1;
    ifc.fix_dec = 1'b1;
    step();
    idle_in();
    tests++;
    if (ifc.address_high_out !== 8'h40 || ifc.fix_err !== 1'b1) begin
      fails++;
      $display("FAIL t5_both pch=%h err=%b exp=40/1",
               ifc.address_high_out, ifc.fix_err);
    end
    step();
    step();
    load(8'h41);
    tests++;
    if (ifc.fix_err !== 1'b1 || ifc.address_high_out !== 8'h41) begin
      fails++;
      $display("FAIL t5_sticky err=%b pch=%h exp=1/41",
               ifc.fix_err, ifc.address_high_out);
    end
  endtask

  task automatic test_async_reset();
    load(8'h50);
    ifc.carry_to_pch = 1'b1;
    step();
    tests++;
    if (ifc.carry_done !== 1'b1 || ifc.address_high_out !== 8'h51) begin
      fails++;
      $display("FAIL t6_pre done=%b pch=%h exp=1/51",
               ifc.carry_done, ifc.address_high_out);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (ifc.address_high_out !== 8'hFF || ifc.carry_done !== 1'b0 ||
        ifc.fix_err !== 1'b0) begin
      fails++;
      $display("FAIL t6_async pch=%h done=%b err=%b exp=ff/0/0",
               ifc.address_high_out, ifc.carry_done, ifc.fix_err);
    end
    @(negedge fclk);
    reset = 1'b0;
    step();
    tests++;
    if (ifc.address_high_out !== 8'h00 || ifc.wrap !== 1'b1 ||
        ifc.carry_done !== 1'b1) begin
      fails++;
      $display("FAIL t6_release pch=%h wrap=%b done=%b exp=00/1/1",
               ifc.address_high_out, ifc.wrap, ifc.carry_done);
    end
    ifc.carry_to_pch = 1'b0;
    step();
  endtask

  initial begin
    idle_in();
    #12;
    test_reset();
    @(negedge fclk);
    reset = 1'b0;
    test_carry();
    test_wrap();
    test_load_priority();
    test_carry_fix();
    test_fix_in_ack();
    test_fix_err();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
